// File: rtl/regfile_alu_shared_pkg.sv
// Types shared between the register file and the ALU side of the datapath.
package regfile_alu_shared_pkg;

  typedef enum logic [1:0] {
    WR_NONE   = 2'b00,
    WR_LATCHC = 2'b01,
    WR_ALU_WE = 2'b10,
    WR_RSVD   = 2'b11
  } wr_mode_t;

endpackage

// File: rtl/regfile_pkg.sv
// Register-file command bus types: commands, selects, bus-master FSM states and capture tags.
package regfile_pkg;

  localparam int INDEX_WIDTH    = 3;
  localparam int SEL_PACK_WIDTH = 3 * INDEX_WIDTH;

  typedef logic [INDEX_WIDTH-1:0] reg_addr_t;
  localparam reg_addr_t R_ZERO = '0;

  typedef enum logic [3:0] {
    COM_NOP      = 4'h0,
    COM_LATCHSEL = 4'h1,
    COM_READA    = 4'h2,
    COM_READB    = 4'h3,
    COM_READF    = 4'h4,
    COM_LATCHC   = 4'h5,
    COM_ALU_WE   = 4'h6,
    COM_SP_WE    = 4'h7
  } command_t;

  // Encodings are ordered: the sequencer relies on issue order == numeric order.
  typedef logic [2:0] bus_state_t;
  localparam bus_state_t ST_IDLE     = 3'd0;
  localparam bus_state_t ST_LATCHSEL = 3'd1;
  localparam bus_state_t ST_READA    = 3'd2;
  localparam bus_state_t ST_READB    = 3'd3;
  localparam bus_state_t ST_READF    = 3'd4;
  localparam bus_state_t ST_WRITE    = 3'd5;
  localparam bus_state_t ST_SPWE     = 3'd6;
  localparam bus_state_t ST_DRAIN    = 3'd7;

  typedef enum logic [1:0] {
    CAP_NONE = 2'd0,
    CAP_A    = 2'd1,
    CAP_B    = 2'd2,
    CAP_F    = 2'd3
  } cap_tag_t;

endpackage

// File: rtl/regfile_bus_capture.sv
// Read-data capture: a one-deep tag pipeline grabs i_Data the cycle after each READx.
module regfile_bus_capture #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  regfile_pkg::command_t i_Command,
  input  logic [WORD_WIDTH-1:0] i_Data,
  output logic [WORD_WIDTH-1:0] o_DataA,
  output logic [WORD_WIDTH-1:0] o_DataB,
  output logic [WORD_WIDTH-1:0] o_Flags
);
  import regfile_pkg::*;

  cap_tag_t tag_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      tag_q   <= CAP_NONE;
      o_DataA <= '0;
      o_DataB <= '0;
      o_Flags <= '0;
    end else begin
      case (tag_q)
        CAP_A:   o_DataA <= i_Data;
        CAP_B:   o_DataB <= i_Data;
        CAP_F:   o_Flags <= i_Data;
        default: ;
      endcase
      case (i_Command)
        COM_READA: tag_q <= CAP_A;
        COM_READB: tag_q <= CAP_B;
        COM_READF: tag_q <= CAP_F;
        default:   tag_q <= CAP_NONE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_bus_master.sv
// Register-file bus initiator: turns one request into an ordered burst of bus commands
// and returns captured read data in a single response pulse.
module regfile_bus_master #(
  parameter int WORD_WIDTH  = 16,
  parameter int INDEX_WIDTH = regfile_pkg::INDEX_WIDTH
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_ReqValid,
  output logic                   o_ReqReady,
  input  logic [INDEX_WIDTH-1:0] i_SelA,
  input  logic [INDEX_WIDTH-1:0] i_SelB,
  input  logic [INDEX_WIDTH-1:0] i_SelC,
  input  logic                   i_RdA,
  input  logic                   i_RdB,
  input  logic                   i_RdF,
  input  logic [1:0]             i_WrMode,
  input  logic [WORD_WIDTH-1:0]  i_WrData,
  input  logic                   i_SpWe,
  input  logic [WORD_WIDTH-1:0]  i_SpData,
  output regfile_pkg::command_t  o_Command,
  output logic [WORD_WIDTH-1:0]  o_Data,
  input  logic [WORD_WIDTH-1:0]  i_Data,
  output logic                   o_RspValid,
  output logic [WORD_WIDTH-1:0]  o_DataA,
  output logic [WORD_WIDTH-1:0]  o_DataB,
  output logic [WORD_WIDTH-1:0]  o_Flags
);
  import regfile_pkg::*;
  import regfile_alu_shared_pkg::*;

  localparam int SEL_W = 3 * INDEX_WIDTH;

  typedef struct packed {
    logic [SEL_W-1:0]      sel;
    logic                  rd_a;
    logic                  rd_b;
    logic                  rd_f;
    wr_mode_t              wr_mode;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  sp_we;
    logic [WORD_WIDTH-1:0] sp_data;
    logic                  need_sel;
  } req_t;

  bus_state_t            state, state_nxt;
  req_t                  req_q, req_in, cur;
  logic [SEL_W-1:0]      shadow;
  logic                  shadow_vld;
  logic                  accept;
  command_t              cmd_nxt;
  logic [WORD_WIDTH-1:0] data_nxt;

  assign o_ReqReady = (state == ST_IDLE);
  assign accept     = i_ReqValid && o_ReqReady;

  always_comb begin
    req_in          = '0;
    req_in.sel      = {i_SelC, i_SelB, i_SelA};
    req_in.rd_a     = i_RdA;
    req_in.rd_b     = i_RdB;
    req_in.rd_f     = i_RdF;
    req_in.wr_mode  = wr_mode_t'(i_WrMode);
    req_in.wr_data  = i_WrData;
    req_in.sp_we    = i_SpWe;
    req_in.sp_data  = i_SpData;
    req_in.need_sel = !shadow_vld || (req_in.sel != shadow);
  end

  // Outputs for the next state are built at the transition edge, so in IDLE
  // the live request fields feed the first issued command directly.
  assign cur = (state == ST_IDLE) ? req_in : req_q;

  function automatic bus_state_t next_issue(input bus_state_t from, input req_t r);
    if (from <  ST_LATCHSEL && r.need_sel) return ST_LATCHSEL;
    if (from <  ST_READA    && r.rd_a)     return ST_READA;
    if (from <  ST_READB    && r.rd_b)     return ST_READB;
    if (from <  ST_READF    && r.rd_f)     return ST_READF;
    if (from <  ST_WRITE    && (r.wr_mode == WR_LATCHC || r.wr_mode == WR_ALU_WE))
      return ST_WRITE;
    if (from <  ST_SPWE     && r.sp_we)    return ST_SPWE;
    return ST_DRAIN;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = next_issue(ST_IDLE, req_in);
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = next_issue(state, req_q);
    endcase
  end

  always_comb begin
    cmd_nxt  = COM_NOP;
    data_nxt = '0;
    case (state_nxt)
      ST_LATCHSEL: begin
        cmd_nxt  = COM_LATCHSEL;
        data_nxt = WORD_WIDTH'(cur.sel);
      end
      ST_READA: cmd_nxt = COM_READA;
      ST_READB: cmd_nxt = COM_READB;
      ST_READF: cmd_nxt = COM_READF;
      ST_WRITE: begin
        if (cur.wr_mode == WR_LATCHC) begin
          cmd_nxt  = COM_LATCHC;
          data_nxt = cur.wr_data;
        end else begin
          cmd_nxt  = COM_ALU_WE;
        end
      end
      ST_SPWE: begin
        cmd_nxt  = COM_SP_WE;
        data_nxt = cur.sp_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      shadow     <= '0;
      shadow_vld <= 1'b0;
      o_Command  <= COM_NOP;
      o_Data     <= '0;
      o_RspValid <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_Command  <= cmd_nxt;
      o_Data     <= data_nxt;
      o_RspValid <= (state == ST_DRAIN);
      if (accept) req_q <= req_in;
      if (state_nxt == ST_LATCHSEL) begin
        shadow     <= cur.sel;
        shadow_vld <= 1'b1;
      end
    end
  end

  regfile_bus_capture #(.WORD_WIDTH(WORD_WIDTH)) u_capture (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Command (o_Command),
    .i_Data    (i_Data),
    .o_DataA   (o_DataA),
    .o_DataB   (o_DataB),
    .o_Flags   (o_Flags)
  );

endmodule

// File: tb/tb_regfile_bus_master.sv
// Directed bench for regfile_bus_master: command sequencing, read capture, handshake and reset abort.
module tb_regfile_bus_master;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  sel_a, sel_b, sel_c;
  logic        rd_a, rd_b, rd_f, sp_we;
  logic [1:0]  wr_mode;
  logic [15:0] wr_data, sp_data, bus_in;
  command_t    cmd;
  logic [15:0] bus_out, data_a, data_b, flags;
  logic        rsp_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_bus_master #(.WORD_WIDTH(16), .INDEX_WIDTH(3)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_ReqValid(req_valid), .o_ReqReady(req_ready),
    .i_SelA(sel_a), .i_SelB(sel_b), .i_SelC(sel_c),
    .i_RdA(rd_a), .i_RdB(rd_b), .i_RdF(rd_f),
    .i_WrMode(wr_mode), .i_WrData(wr_data), .i_SpWe(sp_we), .i_SpData(sp_data),
    .o_Command(cmd), .o_Data(bus_out), .i_Data(bus_in),
    .o_RspValid(rsp_valid), .o_DataA(data_a), .o_DataB(data_b), .o_Flags(flags)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] a, b, c, input logic ra, rb, rf,
                       input logic [1:0] wm, input logic [15:0] wd, input logic sw,
                       input logic [15:0] sd);
    req_valid = v; sel_a = a; sel_b = b; sel_c = c;
    rd_a = ra; rd_b = rb; rd_f = rf; wr_mode = wm; wr_data = wd; sp_we = sw; sp_data = sd;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_in = 16'h0; idle();
    step(); step();
    checks++; if (cmd !== COM_NOP) begin errors++; $display("FAIL reset_cmd got=%0d exp=%0d", cmd, COM_NOP); end
    checks++; if (bus_out !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", bus_out); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%b exp=0", rsp_valid); end
    checks++; if ({data_a, data_b, flags} !== 48'h0) begin errors++; $display("FAIL reset_capture got=%h %h %h exp=0", data_a, data_b, flags); end
    rst = 1'b0; step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_fresh_read();
    drive(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0, 16'h0);
    step(); idle();
    checks++; if (cmd !== COM_LATCHSEL) begin errors++; $display("FAIL fresh_c1 got=%0d exp=%0d", cmd, COM_LATCHSEL); end
    checks++; if (bus_out !== 16'h00D1) begin errors++; $display("FAIL fresh_sel got=%h exp=00d1", bus_out); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fresh_busy got=%b exp=0", req_ready); end
    step();
    checks++; if (cmd !== COM_READA) begin errors++; $display("FAIL fresh_c2 got=%0d exp=%0d", cmd, COM_READA); end
    step(); bus_in = 16'h1111;
    checks++; if (cmd !== COM_READB) begin errors++; $display("FAIL fresh_c3 got=%0d exp=%0d", cmd, COM_READB); end
    step(); bus_in = 16'h2222;
    checks++; if (cmd !== COM_NOP) begin errors++; $display("FAIL fresh_drain got=%0d exp=%0d", cmd, COM_NOP); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fresh_early_rsp got=%b exp=0", rsp_valid); end
    step(); bus_in = 16'h0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL fresh_rsp got=%b exp=1", rsp_valid); end
    checks++; if (data_a !== 16'h1111) begin errors++; $display("FAIL fresh_a got=%h exp=1111", data_a); end
    checks++; if (data_b !== 16'h2222) begin errors++; $display("FAIL fresh_b got=%h exp=2222", data_b); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fresh_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_shadow_hit();
    drive(1'b1, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0, 1'b0, 16'h0);
    step(); idle();
    checks++; if (cmd !== COM_READF) begin errors++; $display("FAIL hit_c1 got=%0d exp=%0d", cmd, COM_READF); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hit_pulse_len got=%b exp=0", rsp_valid); end
    step(); bus_in = 16'hF00F;
    checks++; if (cmd !== COM_NOP) begin errors++; $display("FAIL hit_drain got=%0d exp=%0d", cmd, COM_NOP); end
    step(); bus_in = 16'h0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hit_rsp got=%b exp=1", rsp_valid); end
    checks++; if (flags !== 16'hF00F) begin errors++; $display("FAIL hit_flags got=%h exp=f00f", flags); end
    checks++; if (data_a !== 16'h1111) begin errors++; $display("FAIL hit_a_kept got=%h exp=1111", data_a); end
  endtask

  task automatic test_write();
    drive(1'b1, 3'd4, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 2'b01, 16'hBEEF, 1'b1, 16'h0FF0);
    step(); idle();
    checks++; if (cmd !== COM_LATCHSEL || bus_out !== 16'h01AC) begin errors++; $display("FAIL wr_sel got=%0d/%h exp=%0d/01ac", cmd, bus_out, COM_LATCHSEL); end
    step();
    checks++; if (cmd !== COM_LATCHC || bus_out !== 16'hBEEF) begin errors++; $display("FAIL wr_latchc got=%0d/%h exp=%0d/beef", cmd, bus_out, COM_LATCHC); end
    step();
    checks++; if (cmd !== COM_SP_WE || bus_out !== 16'h0FF0) begin errors++; $display("FAIL wr_spwe got=%0d/%h exp=%0d/0ff0", cmd, bus_out, COM_SP_WE); end
    step();
    checks++; if (cmd !== COM_NOP || bus_out !== 16'h0) begin errors++; $display("FAIL wr_drain got=%0d/%h exp=%0d/0000", cmd, bus_out, COM_NOP); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp got=%b exp=1", rsp_valid); end
    drive(1'b1, 3'd4, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 2'b10, 16'h1234, 1'b0, 16'h0);
    step(); idle();
    checks++; if (cmd !== COM_ALU_WE || bus_out !== 16'h0) begin errors++; $display("FAIL alu_we got=%0d/%h exp=%0d/0000", cmd, bus_out, COM_ALU_WE); end
    step(); step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL alu_rsp got=%b exp=1", rsp_valid); end
    drive(1'b1, 3'd4, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 2'b11, 16'h5555, 1'b0, 16'h0);
    step(); idle();
    checks++; if (cmd !== COM_NOP) begin errors++; $display("FAIL wm11_none got=%0d exp=%0d", cmd, COM_NOP); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wm11_rsp got=%b exp=1", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'd4, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 1'b0, 16'h0);
    step();
    checks++; if (cmd !== COM_NOP || req_ready !== 1'b0) begin errors++; $display("FAIL empty_drain got=%0d/%b exp=%0d/0", cmd, req_ready, COM_NOP); end
    drive(1'b1, 3'd4, 3'd5, 3'd6, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 1'b0, 16'h0);
    step();
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL empty_rsp got=%b/%b exp=1/1", rsp_valid, req_ready); end
    step(); idle();
    checks++; if (cmd !== COM_READA) begin errors++; $display("FAIL b2b_c1 got=%0d exp=%0d", cmd, COM_READA); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b exp=0", rsp_valid); end
    step(); bus_in = 16'h3333;
    step(); bus_in = 16'h0;
    checks++; if (rsp_valid !== 1'b1 || data_a !== 16'h3333) begin errors++; $display("FAIL b2b_rsp got=%b/%h exp=1/3333", rsp_valid, data_a); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0, 16'h0);
    step(); idle();
    checks++; if (cmd !== COM_LATCHSEL) begin errors++; $display("FAIL mid_sel got=%0d exp=%0d", cmd, COM_LATCHSEL); end
    step(); step();
    checks++; if (cmd !== COM_READB) begin errors++; $display("FAIL mid_readb got=%0d exp=%0d", cmd, COM_READB); end
    rst = 1'b1; bus_in = 16'h7777;
    step();
    checks++; if (cmd !== COM_NOP || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_abort got=%0d/%b exp=%0d/0", cmd, rsp_valid, COM_NOP); end
    checks++; if (data_a !== 16'h0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_state got=%h/%b exp=0000/1", data_a, req_ready); end
    rst = 1'b0; bus_in = 16'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b0 || cmd !== COM_NOP) begin errors++; $display("FAIL mid_quiet%0d got=%b/%0d exp=0/%0d", i, rsp_valid, cmd, COM_NOP); end
    end
    drive(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0, 16'h0);
    step(); idle();
    checks++; if (cmd !== COM_LATCHSEL || bus_out !== 16'h00D1) begin errors++; $display("FAIL mid_relatch got=%0d/%h exp=%0d/00d1", cmd, bus_out, COM_LATCHSEL); end
    step(); step(); bus_in = 16'hAAAA;
    step(); bus_in = 16'hBBBB;
    step(); bus_in = 16'h0;
    checks++; if (rsp_valid !== 1'b1 || data_a !== 16'hAAAA || data_b !== 16'hBBBB) begin errors++; $display("FAIL mid_redo got=%b/%h/%h exp=1/aaaa/bbbb", rsp_valid, data_a, data_b); end
  endtask

  initial begin
    rst = 1'b1; bus_in = 16'h0; idle();
    test_reset();
    test_fresh_read();
    test_shadow_hit();
    test_write();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_bus_master.md
Name: regfile_bus_master

Overview:
- Initiator side of the register-file command bus.
- Accepts one register-file transaction per request and sequences it into `command_t` bus cycles: LATCHSEL, READA, READB, READF, then LATCHC or ALU_WE, then SP_WE.
- Captures read data and returns it in a single response pulse.
- Sits between the control unit and the register file, so the control unit never drives raw bus commands.

Parameters:
- WORD_WIDTH, 16, width of the bus data and register words.
- INDEX_WIDTH, 3, register index width; must equal `regfile_pkg::INDEX_WIDTH`.

Ports:
- i_Clk  in  1  system clock; single clock domain.
- i_Reset  in  1  synchronous, active-high reset.
- i_ReqValid  in  1  request valid.
- o_ReqReady  out  1  request accepted when valid & ready.
- i_SelA, i_SelB, i_SelC  in  INDEX_WIDTH each  `reg_addr_t` selects.
- i_RdA, i_RdB, i_RdF  in  1 each  perform READA / READB / READF.
- i_WrMode  in  2  `wr_mode_t`: 00 none, 01 LATCHC from i_WrData, 10 ALU_WE, 11 treated as none.
- i_WrData  in  WORD_WIDTH  data for LATCHC.
- i_SpWe  in  1  perform SP_WE.
- i_SpData  in  WORD_WIDTH  data for SP_WE.
- o_Command  out  4  `command_t` driven to the register file.
- o_Data  out  WORD_WIDTH  bus data to the register file.
- i_Data  in  WORD_WIDTH  read data from the register file, valid one cycle after a READx command.
- o_RspValid  out  1  one-cycle response pulse.
- o_DataA, o_DataB, o_Flags  out  WORD_WIDTH each  captured read data.

Behaviour:
- **Reset values:** o_Command=COM_NOP, o_Data=0, o_RspValid=0, o_DataA/B/Flags=0, FSM=IDLE, select shadow invalid.
- **Request handshake:** o_ReqReady=1 only in IDLE and combinational from state. On acceptance, all request fields are registered; inputs are don't-care afterwards.
- **FSM states:** IDLE, LATCHSEL, READA, READB, READF, WRITE, SPWE, DRAIN. Each state is one cycle. States whose operation is not requested are skipped; the order is fixed as listed.
- **Registered bus outputs:** o_Command and o_Data are registered. The command for a state appears during the cycle the FSM is in that state. o_Command=COM_NOP in IDLE and DRAIN.
- **LATCHSEL cycle:**
  - Issued only if the shadow is invalid, or if {SelC,SelB,SelA} differs from the shadow.
  - o_Data[3*INDEX_WIDTH-1:0] = {SelC,SelB,SelA}; upper bits are 0.
  - The shadow is updated and marked valid in the same cycle.
- **WRITE cycle:**
  - Mode 01: COM_LATCHC with o_Data=WrData.
  - Mode 10: COM_ALU_WE with o_Data=0.
  - Writes to R_ZERO are still issued.
- **SPWE cycle:** COM_SP_WE with o_Data=SpData.
- **Read capture:**
  - A read issued in cycle N is captured from i_Data at the end of cycle N+1.
  - A pending-capture tag (none/A/B/F) pipelines this, so back-to-back reads need no stall.
  - Fields not read in a transaction keep their previous values.
- **DRAIN:** always entered after the last issued state, or directly from acceptance if nothing needs issuing. It captures any outstanding read.
- **Response:** the cycle after DRAIN, o_RspValid=1 for exactly one cycle, the FSM is back in IDLE, and o_ReqReady=1. A new request can be accepted in that same cycle.
- **Latency:** from acceptance to o_RspValid is 2 + (number of issued states) cycles. Example: READA only, shadow matching: cmd at +1, DRAIN at +2, RspValid at +3.
- **Responses:** there is no response backpressure; the consumer must take the pulse.
- **Reset mid-transaction:** the FSM aborts to IDLE, no response is produced, the shadow is invalidated, and the next cycle's command is NOP.

Decomposition:
- Add `wr_mode_t` to `regfile_alu_shared_pkg`.
- Add these to `regfile_pkg`:
  - FSM state enum `bus_state_t`.
  - Capture tag enum.
  - `SEL_PACK_WIDTH = 3*INDEX_WIDTH`.
- Reuse `command_t` and `reg_addr_t` from `regfile_pkg`.
- No sub-module is needed; an optional `regfile_bus_capture` can hold the tag pipeline and capture registers.

Test Plan:
- **Fresh shadow read:** after reset, request Sel=(A1,B2,C3) with RdA, RdB -> cmds LATCHSEL (o_Data=0x0D1), READA, READB, NOP. i_Data=0x1111 and 0x2222 in the following cycles -> o_DataA=0x1111, o_DataB=0x2222, RspValid 5 cycles after acceptance.
- **Shadow hit:** repeat the same selects with RdF only -> no LATCHSEL; READF, DRAIN, RspValid at +3. o_Flags = i_Data from the DRAIN cycle; o_DataA is unchanged.
- **Full write transaction:** WrMode=01, WrData=0xBEEF, SpWe with SpData=0x0FF0, new selects -> LATCHSEL, LATCHC/0xBEEF, SP_WE/0x0FF0, NOP. WrMode=10 -> ALU_WE with o_Data=0; WrMode=11 -> no write cycle.
- **Empty request:** no ops, selects matching the shadow -> only DRAIN, RspValid at +2. A back-to-back request held valid is accepted in the RspValid cycle.
- **Reset mid-transaction:** assert i_Reset during READB -> next cycle o_Command=NOP and no RspValid. The next identical request issues LATCHSEL again.
